rx_iq_packer: RTL and testbench

//  Upstream neighbour of the SMI read path: pairs RX I/Q samples from the LVDS deserializer into framed
//  32-bit words and pushes them into the RX FIFO that the SMI controller drains byte-wise to the host.

---
 rtl/rx_iq_packer.sv | 179 +++++++++++++++++
 tb/tb_rx_iq_packer.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/rx_iq_packer.sv
// RX I/Q pairing stage: frames I/Q sample pairs (or an internal ramp) into 32-bit
// words for the RX FIFO, with sticky drop/pairing-error status and saturating counters.
module rx_iq_packer #(
    parameter int SAMPLE_W = 13,
    parameter int CNT_W    = 16
) (
    input  logic                i_sys_clk,
    input  logic                i_rst,
    input  logic                i_enable,
    input  logic                i_test_mode,
    input  logic                i_iq_valid,
    input  logic                i_iq_is_i,
    input  logic [SAMPLE_W-1:0] i_iq_data,
    output logic                o_fifo_push,
    output logic [31:0]         o_fifo_data,
    input  logic                i_fifo_full,
    input  logic                i_clear_status,
    output logic                o_overflow,
    output logic                o_sync_error,
    output logic [CNT_W-1:0]    o_overflow_cnt,
    output logic [CNT_W-1:0]    o_sync_err_cnt,
    output logic                o_streaming
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ARM    = 2'd1,
        STREAM = 2'd2
    } state_t;

    // Marker bits 31:30 and 15:14 let the host realign on the byte stream.
    function automatic logic [31:0] pack_word(input logic [SAMPLE_W-1:0] i_s,
                                              input logic [SAMPLE_W-1:0] q_s);
        return {2'b10, i_s, 1'b0, 2'b01, q_s, 1'b0};
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (c == {CNT_W{1'b1}}) ? c : c + CNT_W'(1);
    endfunction

    state_t              state_q, state_d;
    logic                pend_q, pend_d;
    logic [SAMPLE_W-1:0] pend_i_q, pend_i_d;
    logic [SAMPLE_W-1:0] ramp_q, ramp_d;
    logic                tm_q, tm_d;
    logic                push_q, push_d;
    logic [31:0]         data_q, data_d;
    logic                ovf_q, ovf_d;
    logic                sync_q, sync_d;
    logic [CNT_W-1:0]    ovf_cnt_q, ovf_cnt_d;
    logic [CNT_W-1:0]    sync_cnt_q, sync_cnt_d;
    logic                streaming_q, streaming_d;

    logic                pend_eff_s;
    logic                complete_s;
    logic                sync_hit_s;
    logic [31:0]         word_s;
    logic                drop_s;

    // Sample pairing, test-ramp substitution and FSM next state.
    always_comb begin
        state_d    = state_q;
        pend_d     = pend_q;
        pend_i_d   = pend_i_q;
        ramp_d     = ramp_q;
        tm_d       = i_test_mode;
        pend_eff_s = 1'b0;
        complete_s = 1'b0;
        sync_hit_s = 1'b0;
        word_s     = 32'h0000_0000;
        if (!i_enable) begin
            state_d = IDLE;
            pend_d  = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    state_d = ARM;
                    pend_d  = 1'b0;
                    ramp_d  = {SAMPLE_W{1'b0}};
                end
                ARM, STREAM: begin
                    // A test-mode toggle silently drops any half-formed pair.
                    pend_eff_s = pend_q & (i_test_mode == tm_q);
                    pend_d     = pend_eff_s;
                    if (!i_iq_valid) begin
                        pend_d = pend_eff_s;
                    end else if (i_test_mode) begin
                        if (i_iq_is_i) begin
                            complete_s = 1'b1;
                            word_s     = pack_word(ramp_q, ~ramp_q);
                            ramp_d     = ramp_q + SAMPLE_W'(1);
                            state_d    = STREAM;
                        end else begin
                            complete_s = 1'b0;
                        end
                    end else if (i_iq_is_i) begin
                        sync_hit_s = (state_q == STREAM) && pend_eff_s;
                        pend_d     = 1'b1;
                        pend_i_d   = i_iq_data;
                        state_d    = STREAM;
                    end else if (state_q == STREAM) begin
                        if (pend_eff_s) begin
                            complete_s = 1'b1;
                            word_s     = pack_word(pend_i_q, i_iq_data);
                            pend_d     = 1'b0;
                        end else begin
                            sync_hit_s = 1'b1;
                        end
                    end else begin
                        pend_d = 1'b0;
                    end
                end
                default: begin
                    state_d = IDLE;
                    pend_d  = 1'b0;
                end
            endcase
        end
    end

    // Push decision, held data word, sticky status and saturating counters.
    always_comb begin
        drop_s      = complete_s & i_fifo_full;
        push_d      = complete_s & ~i_fifo_full;
        data_d      = push_d ? word_s : data_q;
        streaming_d = (state_d == STREAM);
        if (i_clear_status) begin
            ovf_d      = 1'b0;
            sync_d     = 1'b0;
            ovf_cnt_d  = {CNT_W{1'b0}};
            sync_cnt_d = {CNT_W{1'b0}};
        end else begin
            ovf_d      = ovf_q | drop_s;
            sync_d     = sync_q | sync_hit_s;
            ovf_cnt_d  = drop_s ? sat_inc(ovf_cnt_q) : ovf_cnt_q;
            sync_cnt_d = sync_hit_s ? sat_inc(sync_cnt_q) : sync_cnt_q;
        end
    end

    // State and output registers.
    always_ff @(posedge i_sys_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q     <= IDLE;
            pend_q      <= 1'b0;
            pend_i_q    <= {SAMPLE_W{1'b0}};
            ramp_q      <= {SAMPLE_W{1'b0}};
            tm_q        <= 1'b0;
            push_q      <= 1'b0;
            data_q      <= 32'h0000_0000;
            ovf_q       <= 1'b0;
            sync_q      <= 1'b0;
            ovf_cnt_q   <= {CNT_W{1'b0}};
            sync_cnt_q  <= {CNT_W{1'b0}};
            streaming_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            pend_q      <= pend_d;
            pend_i_q    <= pend_i_d;
            ramp_q      <= ramp_d;
            tm_q        <= tm_d;
            push_q      <= push_d;
            data_q      <= data_d;
            ovf_q       <= ovf_d;
            sync_q      <= sync_d;
            ovf_cnt_q   <= ovf_cnt_d;
            sync_cnt_q  <= sync_cnt_d;
            streaming_q <= streaming_d;
        end
    end

    assign o_fifo_push    = push_q;
    assign o_fifo_data    = data_q;
    assign o_overflow     = ovf_q;
    assign o_sync_error   = sync_q;
    assign o_overflow_cnt = ovf_cnt_q;
    assign o_sync_err_cnt = sync_cnt_q;
    assign o_streaming    = streaming_q;

endmodule

// File: tb/tb_rx_iq_packer.sv
// Directed bench for rx_iq_packer: a sample-level model predicts every output each
// cycle, and literal word/counter values pin the model at key points.
module tb_rx_iq_packer;

    logic        clk = 1'b0;
    logic        rst, en, tm, v, isi, full, clr;
    logic [12:0] d;
    logic        push, ovf, serr, strm;
    logic [31:0] data;
    logic [15:0] ovf_cnt, serr_cnt;

    rx_iq_packer #(.SAMPLE_W(13), .CNT_W(16)) dut (
        .i_sys_clk(clk), .i_rst(rst), .i_enable(en), .i_test_mode(tm),
        .i_iq_valid(v), .i_iq_is_i(isi), .i_iq_data(d),
        .o_fifo_push(push), .o_fifo_data(data), .i_fifo_full(full),
        .i_clear_status(clr), .o_overflow(ovf), .o_sync_error(serr),
        .o_overflow_cnt(ovf_cnt), .o_sync_err_cnt(serr_cnt), .o_streaming(strm)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    bit chk_en = 1'b0;

    // Model state: 0 idle, 1 armed (waiting for first I), 2 streaming
    int          m_state;
    bit          m_pend;
    logic [12:0] m_pi, m_ramp;
    bit          m_tm_prev;
    bit          exp_push;
    logic [31:0] exp_data;
    bit          m_ovf, m_sync;
    int          m_ovf_cnt, m_sync_cnt;
    bit          tm_g, full_g;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] word(input logic [12:0] i_s, input logic [12:0] q_s);
        return 32'h8000_4000 + (32'(i_s) * 32'd131072) + (32'(q_s) * 32'd2);
    endfunction

    task automatic model_reset();
        m_state = 0; m_pend = 1'b0; m_pi = 13'd0; m_ramp = 13'd0; m_tm_prev = 1'b0;
        exp_push = 1'b0; exp_data = 32'd0; m_ovf = 1'b0; m_sync = 1'b0;
        m_ovf_cnt = 0; m_sync_cnt = 0;
    endtask

    task automatic model_word(input logic [12:0] i_s, input logic [12:0] q_s);
        if (full) begin
            m_ovf = 1'b1;
            if (m_ovf_cnt < 65535) m_ovf_cnt++;
        end else begin
            exp_push = 1'b1;
            exp_data = word(i_s, q_s);
        end
    endtask

    task automatic model_sync();
        m_sync = 1'b1;
        if (m_sync_cnt < 65535) m_sync_cnt++;
    endtask

    task automatic model_step();
        exp_push = 1'b0;
        if (!en) begin
            m_state = 0; m_pend = 1'b0;
        end else if (m_state == 0) begin
            m_state = 1; m_pend = 1'b0; m_ramp = 13'd0;
        end else begin
            if (tm != m_tm_prev) m_pend = 1'b0;
            if (v && tm && isi) begin
                model_word(m_ramp, ~m_ramp);
                m_ramp = m_ramp + 13'd1;
                m_state = 2;
            end else if (v && !tm && isi) begin
                if (m_state == 2 && m_pend) model_sync();
                m_pend = 1'b1; m_pi = d; m_state = 2;
            end else if (v && !tm && m_state == 2) begin
                if (m_pend) begin
                    model_word(m_pi, d);
                    m_pend = 1'b0;
                end else begin
                    model_sync();
                end
            end
        end
        m_tm_prev = tm;
        if (clr) begin
            m_ovf = 1'b0; m_sync = 1'b0; m_ovf_cnt = 0; m_sync_cnt = 0;
        end
    endtask

    always @(negedge clk) begin
        if (chk_en && !rst) begin
            chk("push", {31'd0, push}, {31'd0, exp_push});
            chk("data", data, exp_data);
            chk("overflow", {31'd0, ovf}, {31'd0, m_ovf});
            chk("sync_error", {31'd0, serr}, {31'd0, m_sync});
            chk("overflow_cnt", {16'd0, ovf_cnt}, 32'(m_ovf_cnt));
            chk("sync_err_cnt", {16'd0, serr_cnt}, 32'(m_sync_cnt));
            chk("streaming", {31'd0, strm}, {31'd0, (m_state == 2)});
        end
    end

    task automatic cyc(input bit e, input bit vv, input bit ii, input logic [12:0] dd,
                       input bit c);
        en = e; tm = tm_g; v = vv; isi = ii; d = dd; full = full_g; clr = c;
        @(posedge clk);
        model_step();
        #2;
        v = 1'b0; clr = 1'b0;
    endtask

    task automatic smp(input bit ii, input logic [12:0] dd);
        cyc(1'b1, 1'b1, ii, dd, 1'b0);
    endtask

    task automatic idle_cyc(input bit e);
        cyc(e, 1'b0, 1'b0, 13'd0, 1'b0);
    endtask

    task automatic zero_outputs(input string tag);
        chk({tag, "_push"}, {31'd0, push}, 32'd0);
        chk({tag, "_data"}, data, 32'd0);
        chk({tag, "_flags"}, {29'd0, ovf, serr, strm}, 32'd0);
        chk({tag, "_cnts"}, {ovf_cnt, serr_cnt}, 32'd0);
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; tm = 1'b0; v = 1'b0; isi = 1'b0; d = 13'd0;
        full = 1'b0; clr = 1'b0; tm_g = 1'b0; full_g = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        zero_outputs("reset");
        #1;
        rst = 1'b0;
        chk_en = 1'b1;

        // Basic pair
        idle_cyc(1'b1);
        smp(1'b1, 13'h0123);
        smp(1'b0, 13'h1ABC);
        chk("t1_push", {31'd0, push}, 32'd1);
        chk("t1_data", data, 32'h8246_7578);
        idle_cyc(1'b1);

        // Q's while armed are dropped without error
        idle_cyc(1'b0);
        idle_cyc(1'b1);
        smp(1'b0, 13'h0111);
        smp(1'b0, 13'h0222);
        smp(1'b1, 13'h0001);
        smp(1'b0, 13'h0002);
        chk("t2_data", data, 32'h8002_4004);
        chk("t2_serr", {16'd0, serr_cnt}, 32'd0);

        // Double I: later I wins, one sync error
        smp(1'b1, 13'd5);
        smp(1'b1, 13'd7);
        smp(1'b0, 13'd9);
        chk("t3_data", data, 32'h800E_4012);
        chk("t3_serr", {16'd0, serr_cnt}, 32'd1);

        // FIFO full across three pairs, then clear
        full_g = 1'b1;
        for (int k = 0; k < 3; k++) begin
            smp(1'b1, 13'(k));
            smp(1'b0, 13'(k + 10));
        end
        full_g = 1'b0;
        chk("t4_ovf_cnt", {16'd0, ovf_cnt}, 32'd3);
        chk("t4_ovf", {31'd0, ovf}, 32'd1);
        cyc(1'b1, 1'b0, 1'b0, 13'd0, 1'b1);
        chk("t4_clr", {15'd0, ovf, ovf_cnt}, 32'd0);

        // Test-mode toggle drops pending I, then lone Q is a sync error
        smp(1'b1, 13'd3);
        tm_g = 1'b1; idle_cyc(1'b1);
        tm_g = 1'b0; idle_cyc(1'b1);
        smp(1'b0, 13'd4);
        chk("tmchg_serr", {16'd0, serr_cnt}, 32'd1);

        // Ramp source through a full wrap
        idle_cyc(1'b0);
        tm_g = 1'b1;
        idle_cyc(1'b1);
        smp(1'b1, 13'h0AAA);
        chk("t5_w0", data, 32'h8000_7FFE);
        smp(1'b0, 13'h0BBB);
        smp(1'b1, 13'h0AAA);
        chk("t5_w1", data, 32'h8002_7FFC);
        full_g = 1'b1; smp(1'b1, 13'd0); full_g = 1'b0;
        for (int k = 3; k <= 8192; k++) smp(1'b1, 13'd0);
        chk("t5_wrap", data, 32'h8000_7FFE);

        // Asynchronous reset with an I pending
        idle_cyc(1'b0);
        tm_g = 1'b0;
        idle_cyc(1'b1);
        smp(1'b1, 13'h0055);
        #3;
        chk_en = 1'b0;
        rst = 1'b1;
        #1;
        zero_outputs("async_rst");
        en = 1'b0;
        repeat (2) @(posedge clk);
        model_reset();
        #2;
        rst = 1'b0;
        chk_en = 1'b1;
        idle_cyc(1'b1);
        smp(1'b0, 13'h0066);
        chk("t6_qdrop", {31'd0, push}, 32'd0);
        chk("t6_serr", {31'd0, serr}, 32'd0);
        smp(1'b1, 13'h0002);
        smp(1'b0, 13'h0003);
        chk("t6_data", data, 32'h8004_4006);
        idle_cyc(1'b1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
